// File: rtl/vio_pgd_pkg.sv
// Shared types and constants for the power-good monitor.
package vio_pgd_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    OFF     = 2'b00,
    RISING  = 2'b01,
    ON      = 2'b10,
    FALLING = 2'b11
  } pgd_state_e;

  // Glitch counters are 8 bits wide and saturate at all-ones.
  localparam int GlitchCntW = 8;
  localparam logic [GlitchCntW-1:0] GlitchCntMax = {GlitchCntW{1'b1}};

  // Larger of two integers, used to size the debounce counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vio_pgd_ch.sv
// One monitored supply: 2-flop synchronizer, debounce FSM with rise/fall
// hysteresis counter, and a saturating glitch counter.

// Plain two-stage synchronizer for asynchronous level inputs.
module prim_flop_2sync #(
  parameter int         Width      = 1,
  parameter logic [0:0] ResetValue = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two back-to-back flops to settle metastability before use.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= {Width{ResetValue}};
      sync_q <= {Width{ResetValue}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

module vio_pgd_ch
  import vio_pgd_pkg::*;
#(
  parameter int RiseCycles = 16,
  parameter int FallCycles = 2,
  parameter int CntW       = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  supp_raw_i,
  input  logic                  ch_en_i,
  input  logic                  glitch_clr_i,
  output logic                  pok_o,
  output logic                  pok_d_o,
  output logic [GlitchCntW-1:0] glitch_cnt_o
);

  localparam logic [CntW-1:0] RiseLast = CntW'(RiseCycles - 1);
  localparam logic [CntW-1:0] FallLast = CntW'(FallCycles - 1);

  logic                  supp_s;
  pgd_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  pok_q, pok_d;
  logic [GlitchCntW-1:0] glitch_q, glitch_d;
  logic                  glitch_evt;

  prim_flop_2sync #(
    .Width     (1),
    .ResetValue(1'b0)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (supp_raw_i),
    .q_o   (supp_s)
  );

  // State, counters and registered pok flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      pok_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pok_q    <= pok_d;
      glitch_q <= glitch_d;
    end
  end

  // Debounce transitions; a disabled channel is parked in OFF and does not
  // record glitches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    glitch_evt = 1'b0;
    if (!ch_en_i) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          if (supp_s) begin
            state_d = RISING;
            cnt_d   = '0;
          end
        end
        RISING: begin
          if (!supp_s) begin
            state_d    = OFF;
            cnt_d      = '0;
            glitch_evt = 1'b1;
          end else if (cnt_q == RiseLast) begin
            state_d = ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ON: begin
          if (!supp_s) begin
            state_d = FALLING;
            cnt_d   = '0;
          end
        end
        FALLING: begin
          if (supp_s) begin
            state_d    = ON;
            cnt_d      = '0;
            glitch_evt = 1'b1;
          end else if (cnt_q == FallLast) begin
            state_d = OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // pok follows the next state so it is asserted in the same cycle the FSM
  // lands in ON; the glitch counter saturates and clear beats increment.
  always_comb begin
    pok_d    = (state_d == ON) || (state_d == FALLING);
    glitch_d = glitch_q;
    if (glitch_clr_i) begin
      glitch_d = '0;
    end else if (glitch_evt && (glitch_q != GlitchCntMax)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  assign pok_o        = pok_q;
  assign pok_d_o      = pok_d;
  assign glitch_cnt_o = glitch_q;

endmodule

// File: rtl/vio_pgd_mon.sv
// Multi-channel power-good monitor: NumCh debounced channels plus the
// aggregate all-good flag and a single change-event pulse.
module vio_pgd_mon
  import vio_pgd_pkg::*;
#(
  parameter int NumCh      = 2,
  parameter int RiseCycles = 16,
  parameter int FallCycles = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumCh-1:0]            supp_raw_i,
  input  logic [NumCh-1:0]            ch_en_i,
  input  logic                        glitch_clr_i,
  output logic [NumCh-1:0]            vio_pok_o,
  output logic                        all_pok_o,
  output logic                        pok_event_o,
  output logic [NumCh*GlitchCntW-1:0] glitch_cnt_o
);

  // Counter must hold the largest terminal count of either direction.
  localparam int CntW = $clog2(max_int(RiseCycles, FallCycles) + 1);

  logic [NumCh-1:0] pok_q;
  logic [NumCh-1:0] pok_d;
  logic             all_pok_q, all_pok_d;
  logic             event_q, event_d;

  for (genvar gi = 0; gi < NumCh; gi++) begin : g_ch
    vio_pgd_ch #(
      .RiseCycles(RiseCycles),
      .FallCycles(FallCycles),
      .CntW      (CntW)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .supp_raw_i  (supp_raw_i[gi]),
      .ch_en_i     (ch_en_i[gi]),
      .glitch_clr_i(glitch_clr_i),
      .pok_o       (pok_q[gi]),
      .pok_d_o     (pok_d[gi]),
      .glitch_cnt_o(glitch_cnt_o[gi*GlitchCntW +: GlitchCntW])
    );
  end

  // Aggregates are computed from next-state pok so they line up with vio_pok_o.
  always_comb begin
    all_pok_d = (|ch_en_i) && (&(pok_d | ~ch_en_i));
    event_d   = |(pok_d ^ pok_q);
  end

  // Register aggregate flag and change pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      all_pok_q <= 1'b0;
      event_q   <= 1'b0;
    end else begin
      all_pok_q <= all_pok_d;
      event_q   <= event_d;
    end
  end

  assign vio_pok_o   = pok_q;
  assign all_pok_o   = all_pok_q;
  assign pok_event_o = event_q;

endmodule

// File: tb/tb_vio_pgd_mon.sv
// Directed bench for vio_pgd_mon with default parameters (2 ch, rise 16, fall 2).
module tb_vio_pgd_mon;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  raw = 2'b00;
  logic [1:0]  en = 2'b11;
  logic        clr = 1'b0;
  logic [1:0]  pok;
  logic        all_pok;
  logic        ev;
  logic [15:0] gcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vio_pgd_mon dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .supp_raw_i  (raw),
    .ch_en_i     (en),
    .glitch_clr_i(clr),
    .vio_pok_o   (pok),
    .all_pok_o   (all_pok),
    .pok_event_o (ev),
    .glitch_cnt_o(gcnt)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (pok !== 2'b00) begin errors++; $display("FAIL reset_pok got %b exp 00", pok); end
    checks++; if (all_pok !== 1'b0) begin errors++; $display("FAIL reset_all got %b exp 0", all_pok); end
    checks++; if (ev !== 1'b0) begin errors++; $display("FAIL reset_event got %b exp 0", ev); end
    checks++; if (gcnt !== 16'h0000) begin errors++; $display("FAIL reset_glitch got %h exp 0000", gcnt); end
    rst_n = 1'b1;
    step(2);
    $display("test_reset done");
  endtask

  task automatic test_rise();
    int ev_n;
    ev_n = 0;
    raw[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      ev_n += int'(ev);
      if (i == 18) begin
        checks++; if (pok[0] !== 1'b0) begin errors++; $display("FAIL rise_early got %b exp 0", pok[0]); end
      end
      if (i == 19) begin
        checks++; if (pok[0] !== 1'b1) begin errors++; $display("FAIL rise_pok got %b exp 1", pok[0]); end
        checks++; if (all_pok !== 1'b0) begin errors++; $display("FAIL rise_all_ch0only got %b exp 0", all_pok); end
      end
    end
    checks++; if (ev_n != 1) begin errors++; $display("FAIL rise_event_count got %0d exp 1", ev_n); end
    raw[1] = 1'b1;
    step(18);
    checks++; if (all_pok !== 1'b0) begin errors++; $display("FAIL rise_all_early got %b exp 0", all_pok); end
    step(1);
    checks++; if (pok !== 2'b11) begin errors++; $display("FAIL rise_both got %b exp 11", pok); end
    checks++; if (all_pok !== 1'b1) begin errors++; $display("FAIL rise_all got %b exp 1", all_pok); end
    $display("test_rise done");
  endtask

  task automatic test_dip();
    int ev_n;
    int low_n;
    ev_n = 0;
    low_n = 0;
    raw[0] = 1'b0;
    step(1);
    raw[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      ev_n += int'(ev);
      if (pok[0] !== 1'b1) low_n++;
    end
    checks++; if (low_n != 0) begin errors++; $display("FAIL dip_pok_low_cycles got %0d exp 0", low_n); end
    checks++; if (ev_n != 0) begin errors++; $display("FAIL dip_events got %0d exp 0", ev_n); end
    checks++; if (gcnt[7:0] !== 8'd1) begin errors++; $display("FAIL dip_glitch got %0d exp 1", gcnt[7:0]); end
    $display("test_dip done");
  endtask

  task automatic test_drop();
    raw[0] = 1'b0;
    step(4);
    checks++; if (pok[0] !== 1'b1) begin errors++; $display("FAIL drop_early got %b exp 1", pok[0]); end
    step(1);
    checks++; if (pok[0] !== 1'b0) begin errors++; $display("FAIL drop_pok got %b exp 0", pok[0]); end
    checks++; if (ev !== 1'b1) begin errors++; $display("FAIL drop_event got %b exp 1", ev); end
    checks++; if (all_pok !== 1'b0) begin errors++; $display("FAIL drop_all got %b exp 0", all_pok); end
    step(1);
    checks++; if (ev !== 1'b0) begin errors++; $display("FAIL drop_event_width got %b exp 0", ev); end
    checks++; if (gcnt[7:0] !== 8'd1) begin errors++; $display("FAIL drop_glitch got %0d exp 1", gcnt[7:0]); end
    $display("test_drop done");
  endtask

  task automatic test_short_pulse();
    int ev_n;
    int hi_n;
    ev_n = 0;
    hi_n = 0;
    raw[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (i == 5) raw[0] = 1'b0;
      ev_n += int'(ev);
      if (pok[0] !== 1'b0) hi_n++;
    end
    checks++; if (hi_n != 0) begin errors++; $display("FAIL short_pok_high_cycles got %0d exp 0", hi_n); end
    checks++; if (ev_n != 0) begin errors++; $display("FAIL short_events got %0d exp 0", ev_n); end
    checks++; if (gcnt[7:0] !== 8'd2) begin errors++; $display("FAIL short_glitch got %0d exp 2", gcnt[7:0]); end
    raw[0] = 1'b1;
    step(20);
    checks++; if (pok !== 2'b11) begin errors++; $display("FAIL short_recover got %b exp 11", pok); end
    $display("test_short_pulse done");
  endtask

  task automatic test_disable();
    en = 2'b01;
    step(1);
    checks++; if (pok !== 2'b01) begin errors++; $display("FAIL dis1_pok got %b exp 01", pok); end
    checks++; if (all_pok !== 1'b1) begin errors++; $display("FAIL dis1_all got %b exp 1", all_pok); end
    checks++; if (ev !== 1'b1) begin errors++; $display("FAIL dis1_event got %b exp 1", ev); end
    step(1);
    checks++; if (ev !== 1'b0) begin errors++; $display("FAIL dis1_event_width got %b exp 0", ev); end
    en = 2'b00;
    step(1);
    checks++; if (pok !== 2'b00) begin errors++; $display("FAIL disall_pok got %b exp 00", pok); end
    checks++; if (all_pok !== 1'b0) begin errors++; $display("FAIL disall_all got %b exp 0", all_pok); end
    checks++; if (ev !== 1'b1) begin errors++; $display("FAIL disall_event got %b exp 1", ev); end
    checks++; if (gcnt[7:0] !== 8'd2) begin errors++; $display("FAIL disall_glitch_hold got %0d exp 2", gcnt[7:0]); end
    en = 2'b11;
    step(16);
    checks++; if (pok !== 2'b00) begin errors++; $display("FAIL reen_early got %b exp 00", pok); end
    step(1);
    checks++; if (pok !== 2'b11) begin errors++; $display("FAIL reen_pok got %b exp 11", pok); end
    $display("test_disable done");
  endtask

  task automatic test_saturate();
    raw[1] = 1'b0;
    step(6);
    checks++; if (pok[1] !== 1'b0) begin errors++; $display("FAIL sat_ch1_off got %b exp 0", pok[1]); end
    for (int i = 0; i < 300; i++) begin
      raw[1] = 1'b1;
      step(1);
      raw[1] = 1'b0;
      step(1);
    end
    step(4);
    checks++; if (gcnt[15:8] !== 8'd255) begin errors++; $display("FAIL sat_ch1 got %0d exp 255", gcnt[15:8]); end
    checks++; if (gcnt[7:0] !== 8'd2) begin errors++; $display("FAIL sat_ch0_untouched got %0d exp 2", gcnt[7:0]); end
    // Pulse launched after edge 0 records its glitch at edge 4; clear rides that same edge.
    raw[1] = 1'b1;
    step(1);
    raw[1] = 1'b0;
    step(2);
    checks++; if (gcnt[15:8] !== 8'd255) begin errors++; $display("FAIL clr_pre got %0d exp 255", gcnt[15:8]); end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++; if (gcnt !== 16'h0000) begin errors++; $display("FAIL clr_wins got %h exp 0000", gcnt); end
    raw[1] = 1'b1;
    step(1);
    raw[1] = 1'b0;
    step(4);
    checks++; if (gcnt[15:8] !== 8'd1) begin errors++; $display("FAIL clr_recount got %0d exp 1", gcnt[15:8]); end
    $display("test_saturate done");
  endtask

  task automatic test_async_reset();
    int ev_n;
    raw[1] = 1'b1;
    step(20);
    checks++; if (pok !== 2'b11) begin errors++; $display("FAIL ares_pre_pok got %b exp 11", pok); end
    checks++; if (all_pok !== 1'b1) begin errors++; $display("FAIL ares_pre_all got %b exp 1", all_pok); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (pok !== 2'b00) begin errors++; $display("FAIL ares_pok got %b exp 00", pok); end
    checks++; if (all_pok !== 1'b0) begin errors++; $display("FAIL ares_all got %b exp 0", all_pok); end
    checks++; if (ev !== 1'b0) begin errors++; $display("FAIL ares_event got %b exp 0", ev); end
    checks++; if (gcnt !== 16'h0000) begin errors++; $display("FAIL ares_glitch got %h exp 0000", gcnt); end
    #2;
    rst_n = 1'b1;
    ev_n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      ev_n += int'(ev);
      if (i == 18) begin
        checks++; if (pok !== 2'b00) begin errors++; $display("FAIL ares_early got %b exp 00", pok); end
      end
      if (i == 19) begin
        checks++; if (pok !== 2'b11) begin errors++; $display("FAIL ares_return got %b exp 11", pok); end
      end
    end
    checks++; if (ev_n != 1) begin errors++; $display("FAIL ares_events got %0d exp 1", ev_n); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_dip();
    test_drop();
    test_short_pulse();
    test_disable();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vio_pgd_mon.md
# vio_pgd_mon

Parametrised multi-channel power-good monitor that turns raw, asynchronous supply-OK indicators from the analog domain into clean, debounced, per-channel `pok` flags. It adds rise and fall hysteresis, per-channel enables, an aggregate all-good flag, a change event and saturating glitch counters. It sits in the AST digital wrapper between the analog supply detectors and the power manager / alert logic.

## Interface
- `NumCh`, default 2: number of monitored supplies (≥1).
- `RiseCycles`, default 16: consecutive synced-high cycles required to declare good (≥1).
- `FallCycles`, default 2: consecutive synced-low cycles required to declare bad (≥1).
- `CntW`, default `$clog2(max(RiseCycles,FallCycles)+1)`: debounce counter width (derived, not overridden).

Ports:
- `clk_i`  in  1  monitor clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `supp_raw_i`  in  NumCh  raw supply-OK, asynchronous to `clk_i`.
- `ch_en_i`  in  NumCh  channel enable, synchronous to `clk_i`.
- `glitch_clr_i`  in  1  synchronous clear of all glitch counters.
- `vio_pok_o`  out  NumCh  debounced power-good per channel.
- `all_pok_o`  out  1  AND of `vio_pok_o` over enabled channels. 0 if no channel is enabled.
- `pok_event_o`  out  1  one-cycle pulse when any `vio_pok_o` bit changes.
- `glitch_cnt_o`  out  NumCh*8  per-channel saturating glitch count, channel i at [8i+7:8i].

## Operation
- Each channel has a 2-flop synchronizer, reset value 0. Its output is `s`.
- Each channel has a 4-state FSM: OFF, RISING, ON, FALLING. The counter `cnt` is CntW bits.
  - OFF: if `s`=1, go to RISING with `cnt`=0.
  - RISING: if `s`=0, go to OFF and count one glitch. Otherwise, if `cnt`==RiseCycles-1, go to ON. Otherwise `cnt`++.
  - ON: if `s`=0, go to FALLING with `cnt`=0.
  - FALLING: if `s`=1, go to ON and count one glitch. Otherwise, if `cnt`==FallCycles-1, go to OFF. Otherwise `cnt`++.
- `vio_pok_o[i]` is registered and equals 1 when the next state is ON or FALLING.
- Channel disable: when `ch_en_i[i]`=0, the FSM is forced to OFF on the next edge, `cnt`=0, and the channel is excluded from `all_pok_o`. Its glitch counter holds its value. The synchronizer keeps running.
- Glitch counter: 8-bit, saturates at 255. When `glitch_clr_i` and an increment occur in the same cycle, the clear wins and the result is 0.
- `all_pok_o` and `pok_event_o` are registered from the next-state `pok` values, so they are aligned with `vio_pok_o`.
- Reset (async assert, any time): all FSMs go to OFF, and all outputs are 0 immediately. `pok_event_o` does not pulse on reset assertion or release.

## Timing
- Reset values: `vio_pok_o`=0, `all_pok_o`=0, `pok_event_o`=0, `glitch_cnt_o`=0.
- Rise latency: raw goes high before edge 0. Then `s`=1 after edge 2, RISING after edge 3, and `vio_pok_o`=1 after edge 3+RiseCycles.
- Fall latency: `vio_pok_o`=0 after edge 3+FallCycles.
- A raw pulse shorter than RiseCycles synced cycles never asserts `pok` and records exactly 1 glitch. The same holds for dips shorter than FallCycles.
- With RiseCycles=1, RISING lasts exactly one cycle. No state is skipped.
- `pok_event_o` is high for exactly 1 cycle per change edge. Simultaneous changes on several channels produce a single pulse.

## Structure
- `vio_pgd_pkg` holds the `pgd_state_e` enum (OFF, RISING, ON, FALLING; 2-bit encoding) and `GlitchCntW`=8.
- Sub-module `vio_pgd_ch` contains one channel: synchronizer (`prim_flop_2sync`), FSM, debounce counter and glitch counter. The top generates NumCh instances and adds the aggregate/event logic.

## Test plan
- Defaults (NumCh=2, Rise=16, Fall=2), both enabled, raw ch0 high at edge 0 → `vio_pok_o[0]`=1 after edge 19. `all_pok_o` stays 0 until ch1 is good. One `pok_event_o` pulse.
- Raw ch0 high for 5 cycles then low → `vio_pok_o[0]` stays 0, `glitch_cnt[0]`=1, no event.
- ch0 ON, raw low for 1 cycle → `pok` stays 1 and glitch=1. Raw low for 3 cycles → `pok` falls after edge 5 from drop, with an event pulse.
- 300 short glitches → counter saturates at 255. `glitch_clr_i` pulsed together with a glitch → counter reads 0.
- ch1 disabled while both are ON → `vio_pok_o[1]`=0 next edge, `all_pok_o` stays 1 (ch0 only), one event. Disable all → `all_pok_o`=0.
- `rst_ni` asserted while both are ON → all outputs 0 without a clock edge. After release with raw high → `pok` returns after RiseCycles+3 edges.
